// File: rtl/data_mem_arbiter_if.sv
// Host/debug command bus into data_mem_arbiter: level request held until a one-cycle ack.
interface data_mem_arbiter_if #(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned DATA_WIDTH = 8
);
    logic                  host_req;
    logic                  host_we;
    logic [ADDR_WIDTH-1:0] host_addr;
    logic [DATA_WIDTH-1:0] host_wdata;
    logic                  host_ack;
    logic [DATA_WIDTH-1:0] host_rdata;
    logic                  host_err;
    logic                  host_busy;

    modport master (
        output host_req, host_we, host_addr, host_wdata,
        input  host_ack, host_rdata, host_err, host_busy
    );

    modport slave (
        input  host_req, host_we, host_addr, host_wdata,
        output host_ack, host_rdata, host_err, host_busy
    );
endinterface

// File: rtl/data_mem_arbiter.sv
// Shares the data RAM between the CPU (absolute priority, zero-latency pass-through) and a queued host port.
// Optional feature macro: ARB_TIMEOUT_EN aborts a host command after HOST_MAX_WAIT busy cycles.
module data_mem_arbiter #(
    parameter int unsigned ADDR_WIDTH    = 8,
    parameter int unsigned DATA_WIDTH    = 8,
    parameter int unsigned HOST_MAX_WAIT = 15,
    parameter int unsigned WAIT_WIDTH    = 4
) (
    input  logic                  clk,
    input  logic                  arst,
    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0] cpu_wdata,
    output logic [DATA_WIDTH-1:0] cpu_rdata,
    data_mem_arbiter_if.slave     host,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic                  ram_we,
    output logic [DATA_WIDTH-1:0] ram_wdata,
    input  logic [DATA_WIDTH-1:0] ram_rdata
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PENDING = 2'd1,
        ISSUED  = 2'd2
    } state_t;

    state_t                r_state;
    logic                  r_we;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic                  r_ack;
    logic                  r_err;
    logic                  r_busy;
    logic                  w_capture;

    if ((64'(1) << WAIT_WIDTH) <= 64'(HOST_MAX_WAIT)) begin : g_cfg_check
        $error("WAIT_WIDTH too small for HOST_MAX_WAIT");
    end

`ifdef ARB_TIMEOUT_EN
    logic [WAIT_WIDTH-1:0] r_wait;
    logic                  r_abort;

    assign w_capture = (r_state == ISSUED) && !r_we && !r_abort;
`else
    assign w_capture = (r_state == ISSUED) && !r_we;
`endif

    // Command sequencing; ack/err/busy are registered so they line up with the ISSUED cycle.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            r_state <= IDLE;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_ack   <= 1'b0;
            r_err   <= 1'b0;
            r_busy  <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            r_wait  <= '0;
            r_abort <= 1'b0;
`endif
        end else begin
            r_ack <= 1'b0;
            r_err <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (host.host_req) begin
                        r_we    <= host.host_we;
                        r_addr  <= host.host_addr;
                        r_wdata <= host.host_wdata;
                        r_busy  <= 1'b1;
                        r_state <= PENDING;
`ifdef ARB_TIMEOUT_EN
                        r_wait  <= '0;
                        r_abort <= 1'b0;
`endif
                    end
                end
                PENDING: begin
                    if (cpu_req) begin
`ifdef ARB_TIMEOUT_EN
                        if (r_wait == WAIT_WIDTH'(HOST_MAX_WAIT)) begin
                            r_abort <= 1'b1;
                            r_ack   <= 1'b1;
                            r_err   <= 1'b1;
                            r_state <= ISSUED;
                        end else if (r_wait != '1) begin
                            r_wait <= r_wait + WAIT_WIDTH'(1);
                        end
`endif
                    end else begin
                        r_ack   <= 1'b1;
                        r_state <= ISSUED;
                    end
                end
                ISSUED: begin
                    if (w_capture) begin
                        r_rdata <= ram_rdata;
                    end
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // RAM mux: CPU always wins; the held command only reaches the RAM on a free PENDING cycle.
    always_comb begin
        ram_addr  = r_addr;
        ram_wdata = r_wdata;
        ram_we    = 1'b0;
        if (cpu_req) begin
            ram_addr  = cpu_addr;
            ram_wdata = cpu_wdata;
            ram_we    = cpu_we;
        end else if (r_state == PENDING) begin
            ram_we = r_we;
        end
    end

    assign cpu_rdata = ram_rdata;

    // Read data arrives from the RAM during ISSUED, so bypass it to be valid alongside host_ack.
    assign host.host_rdata = w_capture ? ram_rdata : r_rdata;
    assign host.host_ack   = r_ack;
    assign host.host_busy  = r_busy;
`ifdef ARB_TIMEOUT_EN
    assign host.host_err   = r_err;
`else
    assign host.host_err   = 1'b0;
`endif

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Scoreboard bench for data_mem_arbiter: random CPU/host traffic against a queue-based memory model.
module tb_data_mem_arbiter;
    localparam int unsigned AW = 8;
    localparam int unsigned DW = 8;

    logic          clk = 1'b0;
    logic          arst;
    logic          cpu_req, cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata, cpu_rdata;
    logic [AW-1:0] ram_addr;
    logic          ram_we;
    logic [DW-1:0] ram_wdata, ram_rdata;

    data_mem_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) hif ();

    data_mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .HOST_MAX_WAIT(15), .WAIT_WIDTH(4)) dut (
        .clk(clk), .arst(arst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .host(hif),
        .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    always #5 clk = ~clk;

    // Synchronous single-port RAM with a preload port used only while the DUT is in reset.
    logic [DW-1:0] ram [256];
    logic          pre_en;
    logic [AW-1:0] pre_addr;
    logic [DW-1:0] pre_data;
    always @(posedge clk) begin
        if (pre_en) ram[pre_addr] <= pre_data;
        else if (ram_we) ram[ram_addr] <= ram_wdata;
        ram_rdata <= ram[ram_addr];
    end

    typedef struct {
        int            cyc;
        logic          err;
        logic [DW-1:0] rdata;
    } exp_t;

    exp_t          sb_q[$];
    int            ack_log[$];
    logic [DW-1:0] ref_mem [256];
    logic [DW-1:0] last_rd;
    logic          lat_we;
    logic [AW-1:0] lat_addr;
    logic [DW-1:0] lat_wdata;
    int            cyc = 0;
    int            n_chk = 0;
    int            n_pass = 0;
    logic          exp_bus_on = 1'b0;
    logic          exp_we;
    logic [AW-1:0] exp_addr;
    logic [DW-1:0] exp_wdata;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    endtask

    // Monitor: RAM bus every cycle, host acks popped from the scoreboard.
    always @(negedge clk) begin
        if (!arst) begin
            if (exp_bus_on) begin
                chk("ram_we", 32'(ram_we), 32'(exp_we));
                chk("ram_addr", 32'(ram_addr), 32'(exp_addr));
                chk("ram_wdata", 32'(ram_wdata), 32'(exp_wdata));
                chk("cpu_rdata", 32'(cpu_rdata), 32'(ram_rdata));
            end
            if (hif.host_ack) begin
                ack_log.push_back(cyc);
                if (sb_q.size() == 0) begin
                    chk("spurious_ack", 32'(1), 32'(0));
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    chk("ack_cycle", 32'(cyc), 32'(e.cyc));
                    chk("host_err", 32'(hif.host_err), 32'(e.err));
                    chk("host_rdata", 32'(hif.host_rdata), 32'(e.rdata));
                    chk("busy_at_ack", 32'(hif.host_busy), 32'(1));
                end
            end
        end
    end

    task automatic drive_cycle(input logic creq, input logic cwe, input logic [AW-1:0] caddr,
                               input logic [DW-1:0] cwdata, input logic hslot);
        cpu_req    = creq;
        cpu_we     = cwe;
        cpu_addr   = caddr;
        cpu_wdata  = cwdata;
        exp_bus_on = 1'b1;
        if (creq) begin
            exp_we = cwe; exp_addr = caddr; exp_wdata = cwdata;
            if (cwe) ref_mem[caddr] = cwdata;
        end else begin
            exp_we = hslot & lat_we; exp_addr = lat_addr; exp_wdata = lat_wdata;
            if (hslot && lat_we) ref_mem[lat_addr] = lat_wdata;
        end
        @(posedge clk); #1;
    endtask

    task automatic cpu_rand(input logic force_busy);
        logic          r, w;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        r = force_busy | 1'($urandom_range(0, 1));
        w = 1'($urandom_range(0, 1));
        a = AW'(8'h40 + 8'($urandom_range(0, 15)));
        d = DW'($urandom);
        drive_cycle(r, r & w, a, d, 1'b0);
    endtask

    // One host command: IDLE cycle, k CPU-busy PENDING cycles, host slot, ISSUED.
    task automatic run_cmd(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                           input int k, input logic keep, input logic force_w,
                           input logic [AW-1:0] fw_addr, input logic [DW-1:0] fw_data);
        logic   aborted;
        exp_t   e;
        hif.host_req = 1'b1; hif.host_we = we; hif.host_addr = addr; hif.host_wdata = wdata;
        cpu_rand(1'b0);
        lat_we = we; lat_addr = addr; lat_wdata = wdata;
        aborted = 1'b0;
        for (int i = 0; i < k; i++) begin
`ifdef ARB_TIMEOUT_EN
            if (i == 15) begin
                aborted = 1'b1;
                e.cyc = cyc + 1; e.err = 1'b1; e.rdata = last_rd;
                sb_q.push_back(e);
                cpu_rand(1'b1);
                break;
            end
`endif
            if (i == 0 && force_w) drive_cycle(1'b1, 1'b1, fw_addr, fw_data, 1'b0);
            else cpu_rand(1'b1);
        end
        if (!aborted) begin
            if (!we) last_rd = ref_mem[addr];
            e.cyc = cyc + 1; e.err = 1'b0; e.rdata = last_rd;
            sb_q.push_back(e);
            drive_cycle(1'b0, 1'b0, 8'h00, 8'h00, 1'b1);
        end
        hif.host_req = keep;
        cpu_rand(1'b0);
    endtask

    task automatic check_reset_outputs(input string nm);
        chk({nm, "_ack"}, 32'(hif.host_ack), 32'(0));
        chk({nm, "_err"}, 32'(hif.host_err), 32'(0));
        chk({nm, "_busy"}, 32'(hif.host_busy), 32'(0));
        chk({nm, "_rdata"}, 32'(hif.host_rdata), 32'(0));
        chk({nm, "_ram_we"}, 32'(ram_we), 32'(0));
        chk({nm, "_ram_addr"}, 32'(ram_addr), 32'(0));
        chk({nm, "_ram_wdata"}, 32'(ram_wdata), 32'(0));
    endtask

    initial begin
        int k;
        arst = 1'b1; pre_en = 1'b0; pre_addr = '0; pre_data = '0;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        hif.host_req = 1'b0; hif.host_we = 1'b0; hif.host_addr = '0; hif.host_wdata = '0;
        lat_we = 1'b0; lat_addr = '0; lat_wdata = '0; last_rd = '0;
        exp_we = 1'b0; exp_addr = '0; exp_wdata = '0;
        for (int i = 0; i < 256; i++) ref_mem[i] = '0;
        ref_mem[8'h10] = 8'hA5;
        ref_mem[8'h30] = 8'h11;
        pre_en = 1'b1;
        for (int i = 0; i < 256; i++) begin
            pre_addr = AW'(i); pre_data = ref_mem[i];
            @(posedge clk); #1;
        end
        pre_en = 1'b0;
        #2 check_reset_outputs("reset");
        @(posedge clk); #1 arst = 1'b0;

        // Idle host read, CPU contention write, CPU write ordered before host read.
        run_cmd(1'b0, 8'h10, 8'h00, 0, 1'b0, 1'b0, 8'h00, 8'h00);
        run_cmd(1'b1, 8'h20, 8'h3C, 5, 1'b0, 1'b0, 8'h00, 8'h00);
        run_cmd(1'b0, 8'h20, 8'h00, 0, 1'b0, 1'b0, 8'h00, 8'h00);
        run_cmd(1'b0, 8'h30, 8'h00, 1, 1'b0, 1'b1, 8'h30, 8'h77);

        // Back-to-back: three commands with host_req held high.
        run_cmd(1'b1, 8'h50, 8'h5A, 0, 1'b1, 1'b0, 8'h00, 8'h00);
        run_cmd(1'b0, 8'h50, 8'h00, 0, 1'b1, 1'b0, 8'h00, 8'h00);
        run_cmd(1'b0, 8'h10, 8'h00, 0, 1'b0, 1'b0, 8'h00, 8'h00);
        drive_cycle(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
        if (ack_log.size() >= 3) begin
            chk("b2b_gap1", 32'(ack_log[ack_log.size()-2] - ack_log[ack_log.size()-3]), 32'(3));
            chk("b2b_gap2", 32'(ack_log[ack_log.size()-1] - ack_log[ack_log.size()-2]), 32'(3));
        end else begin
            chk("b2b_ack_count", 32'(ack_log.size()), 32'(3));
        end

        // Long CPU burst: timeout with ARB_TIMEOUT_EN, otherwise waits for the free cycle.
        run_cmd(1'b1, 8'h60, 8'hEE, 20, 1'b0, 1'b0, 8'h00, 8'h00);
        run_cmd(1'b0, 8'h60, 8'h00, 0, 1'b0, 1'b0, 8'h00, 8'h00);

        // Reset while a command is pending: no ack, outputs cleared, next command normal.
        hif.host_req = 1'b1; hif.host_we = 1'b0; hif.host_addr = 8'h10; hif.host_wdata = 8'h00;
        drive_cycle(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
        lat_we = 1'b0; lat_addr = 8'h10; lat_wdata = 8'h00;
        drive_cycle(1'b1, 1'b0, 8'h41, 8'h00, 1'b0);
        #2;
        exp_bus_on = 1'b0;
        arst = 1'b1; hif.host_req = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0;
        #1 check_reset_outputs("midreset");
        lat_we = 1'b0; lat_addr = '0; lat_wdata = '0; last_rd = '0;
        repeat (2) @(posedge clk);
        #1 arst = 1'b0;
        run_cmd(1'b0, 8'h30, 8'h00, 0, 1'b0, 1'b0, 8'h00, 8'h00);

        // Randomized traffic.
        for (int n = 0; n < 40; n++) begin
            k = ($urandom_range(0, 9) == 0) ? int'($urandom_range(16, 20)) : int'($urandom_range(0, 3));
            run_cmd(1'($urandom_range(0, 1)), AW'(8'h40 + 8'($urandom_range(0, 15))), DW'($urandom),
                    k, 1'b0, 1'b0, 8'h00, 8'h00);
            repeat ($urandom_range(0, 2)) cpu_rand(1'b0);
        end

        repeat (4) cpu_rand(1'b0);
        chk("missing_acks", 32'(sb_q.size()), 32'(0));
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
